alu_nibble_seq: RTL and testbench
=================================

ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

Interface
REQ-001 SHALL have parameter NIB, default 4, giving the number of 4-bit nibbles per operand; operand width W = 4*NIB.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, with reset asynchronous and active-high.
REQ-004 SHALL have req_valid, input, 1: request present.
REQ-005 SHALL have req_ready, output, 1: request accepted when req_valid && req_ready at a rising edge.
REQ-006 SHALL have req_a and req_b, input, W each: operands.
REQ-007 SHALL have req_op, input, 3: opcode, with 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes are illegal.
REQ-008 SHALL have res_valid, output, 1: result available.
REQ-009 SHALL have res_ready, input, 1: result consumed when res_valid && res_ready at a rising edge.
REQ-010 SHALL have res_data, output, W: result.
REQ-011 SHALL have res_cout, res_ovf and res_err, output, 1 each: final carry, signed overflow, illegal opcode.
REQ-012 SHALL have alu_a, alu_b, output, 4 each: nibble operands driven to the external combinational 4-bit ALU slice.
REQ-013 SHALL have alu_op, output, 3, and alu_cin, output, 1: slice opcode and carry-in.
REQ-014 SHALL have alu_result, input, 4, and alu_cout, input, 1: slice outputs, combinational from alu_* within the same cycle.

Function
REQ-015 SHALL implement three states: IDLE, RUN, DONE.
REQ-016 SHALL drive req_ready=1 only in IDLE.
REQ-017 SHALL, on acceptance, latch req_a, req_b and req_op, clear the nibble index k to 0, clear the result register, and enter RUN.
REQ-018 SHALL, in RUN, drive alu_a=a[4k+3:4k] and alu_b=b[4k+3:4k], with alu_op=latched op, except that SLT SHALL drive 110 (SUB).
REQ-019 SHALL drive alu_cin for k=0 as 1 for SUB/SLT and 0 otherwise, and for k>0 as the alu_cout registered at the previous nibble.
REQ-020 SHALL, at each RUN edge, store alu_result into result bits [4k+3:4k], register alu_cout, and increment k.
REQ-021 SHALL enter DONE after capturing nibble NIB-1, so that res_valid rises exactly NIB edges after the accepting edge (4 for the default).
REQ-022 SHALL drive alu_a, alu_b, alu_op and alu_cin to 0 outside RUN.
REQ-023 SHALL set res_cout to the alu_cout of nibble NIB-1 for ADD/SUB/SLT, and 0 for AND/OR.
REQ-024 SHALL set res_ovf=(a[W-1]==b'[W-1]) && (d[W-1]!=a[W-1]) for ADD/SUB, where b'=b for ADD and ~b for SUB, and d is the raw sum/difference; res_ovf SHALL be 0 for other ops.
REQ-025 SHALL, for SLT, set res_data = {W-1 zeros, d[W-1] XOR ovf_sub}, giving a signed compare; res_cout and res_ovf SHALL be 0.
REQ-026 SHALL, for an illegal opcode, still spend NIB RUN cycles with alu_op=000, then report res_data=0, res_err=1, res_cout=0 and res_ovf=0.
REQ-027 SHALL, in DONE, hold res_valid and all res_* outputs stable until res_ready=1, then return to IDLE on that edge.
REQ-028 SHALL accept no new request in the same edge as result consumption; req_ready rises the cycle after.
REQ-029 SHALL ignore req_* changes while in RUN or DONE.
REQ-030 SHALL make res_* outputs don't-care when res_valid=0; they SHALL nevertheless be 0 after reset.

Reset
REQ-031 SHALL, with rst high, immediately force IDLE, k=0, result/carry/flag registers 0, res_valid=0, req_ready=1 and all alu_* outputs 0.
REQ-032 SHALL, on rst asserted mid-RUN or in DONE, abandon the operation with no result ever presented.
REQ-033 SHALL accept a request on the first rising edge after rst deasserts.

Verification
REQ-034 SHALL pass: ADD 0x00FF+0x0001, res_ready=1 -> res_valid exactly 4 edges after accept, res_data=0x0100, res_cout=0, res_ovf=0.
REQ-035 SHALL pass: SUB 0x0000-0x0001 -> res_data=0xFFFF, res_cout=0, res_ovf=0; nibble-0 alu_cin=1, alu_op=110.
REQ-036 SHALL pass: ADD 0x7FFF+0x0001 -> res_data=0x8000, res_ovf=1; SLT a=0x8000, b=0x0001 -> res_data=0x0001; SLT a=0x0001, b=0x8000 -> 0x0000.
REQ-037 SHALL pass: ADD 0xFFFF+0x0001 with res_ready low 3 cycles -> res_data=0x0000 and res_cout=1 held stable, req_ready=0 throughout; consumed on the 4th cycle; req_ready=1 the next cycle.
REQ-038 SHALL pass: rst pulsed after the 2nd RUN nibble -> res_valid never asserts, alu_* outputs return to 0 asynchronously, and the next request (AND 0xF0F0, 0xFF00 -> 0xF000) completes normally.
REQ-039 SHALL pass: opcode 011 -> res_err=1, res_data=0 after 4 cycles, and alu_op=000 observed in every RUN cycle.

Source files
------------

// File: rtl/alu_nibble_seq.sv
// ============================================================================
//  Module   : alu_nibble_seq
//  Purpose  : Sequences a W-bit AND/OR/ADD/SUB/SLT through an external
//             combinational 4-bit ALU slice, one nibble per clock.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_nibble_seq #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4*NIB-1:0] req_a,
    input  logic [4*NIB-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [4*NIB-1:0] res_data,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_err,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    input  logic [3:0]       alu_result,
    input  logic             alu_cout
);

    localparam int W  = 4 * NIB;
    localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [KW-1:0] c_k_last = KW'(NIB - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sub = 3'b110;
    localparam logic [2:0] c_op_slt = 3'b111;

    logic [1:0]    r_state, w_state_next;
    logic [W-1:0]  r_a, r_b, r_res;
    logic [2:0]    r_op;
    logic [KW-1:0] r_k;
    logic          r_carry;
    logic [W-1:0]  r_res_data;
    logic          r_res_cout, r_res_ovf, r_res_err;

    logic [W-1:0]  w_res_next;
    logic [3:0]    w_a_nib, w_b_nib;
    logic          w_sub, w_legal, w_bp_msb, w_ovf_raw;
    logic [W-1:0]  w_fin_data;
    logic          w_fin_cout, w_fin_ovf, w_fin_err;

    assign w_sub   = (r_op == c_op_sub) || (r_op == c_op_slt);
    assign w_legal = (r_op == c_op_and) || (r_op == c_op_or) || (r_op == c_op_add) || w_sub;

    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            if (r_k == KW'(i)) begin
                w_a_nib = r_a[4*i +: 4];
                w_b_nib = r_b[4*i +: 4];
            end
        end
    end

    // Result as it will stand once the current nibble is captured.
    generate
        for (genvar i = 0; i < NIB; i++) begin : g_nib
            assign w_res_next[4*i +: 4] = (r_k == KW'(i)) ? alu_result : r_res[4*i +: 4];
        end
    endgenerate

    assign w_bp_msb  = w_sub ? ~r_b[W-1] : r_b[W-1];
    assign w_ovf_raw = (r_a[W-1] == w_bp_msb) && (w_res_next[W-1] != r_a[W-1]);

    always_comb begin
        w_fin_data = w_res_next;
        w_fin_cout = 1'b0;
        w_fin_ovf  = 1'b0;
        w_fin_err  = 1'b0;
        case (r_op)
            c_op_and, c_op_or: ;
            c_op_add, c_op_sub: begin
                w_fin_cout = alu_cout;
                w_fin_ovf  = w_ovf_raw;
            end
            c_op_slt: w_fin_data = {{(W-1){1'b0}}, w_res_next[W-1] ^ w_ovf_raw};
            default: begin
                w_fin_data = '0;
                w_fin_err  = 1'b1;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (req_valid)        w_state_next = c_st_run;
            c_st_run:  if (r_k == c_k_last)  w_state_next = c_st_done;
            c_st_done: if (res_ready)        w_state_next = c_st_idle;
            default:                         w_state_next = c_st_idle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (r_state == c_st_idle);
        res_valid = (r_state == c_st_done);
        alu_a     = 4'd0;
        alu_b     = 4'd0;
        alu_op    = 3'd0;
        alu_cin   = 1'b0;
        if (r_state == c_st_run) begin
            alu_a   = w_a_nib;
            alu_b   = w_b_nib;
            alu_op  = (r_op == c_op_slt) ? c_op_sub : (w_legal ? r_op : c_op_and);
            alu_cin = (r_k == '0) ? w_sub : r_carry;
        end
    end

    assign res_data = r_res_data;
    assign res_cout = r_res_cout;
    assign res_ovf  = r_res_ovf;
    assign res_err  = r_res_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= 3'd0;
            r_k        <= '0;
            r_res      <= '0;
            r_carry    <= 1'b0;
            r_res_data <= '0;
            r_res_cout <= 1'b0;
            r_res_ovf  <= 1'b0;
            r_res_err  <= 1'b0;
        end else if (r_state == c_st_idle) begin
            if (req_valid) begin
                r_a     <= req_a;
                r_b     <= req_b;
                r_op    <= req_op;
                r_k     <= '0;
                r_res   <= '0;
                r_carry <= 1'b0;
            end
        end else if (r_state == c_st_run) begin
            r_res   <= w_res_next;
            r_carry <= alu_cout;
            r_k     <= r_k + KW'(1);
            if (r_k == c_k_last) begin
                r_res_data <= w_fin_data;
                r_res_cout <= w_fin_cout;
                r_res_ovf  <= w_fin_ovf;
                r_res_err  <= w_fin_err;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_nibble_seq.sv
// ============================================================================
//  Module   : tb_alu_nibble_seq
//  Purpose  : Directed self-checking bench for alu_nibble_seq with a
//             behavioural 4-bit ALU slice attached.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_nibble_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [2:0]  req_op;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic        res_cout, res_ovf, res_err;
    logic [3:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_cin, alu_cout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_nibble_seq #(.NIB(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cout(res_cout), .res_ovf(res_ovf), .res_err(res_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    // External 4-bit slice
    always_comb begin
        logic [4:0] s;
        s = 5'd0;
        case (alu_op)
            3'b000: s = {1'b0, alu_a & alu_b};
            3'b001: s = {1'b0, alu_a | alu_b};
            3'b010: s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
            3'b110: s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
            default: s = 5'd0;
        endcase
        alu_result = s[3:0];
        alu_cout   = s[4];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input int stall, input logic [15:0] ed,
                          input logic ec, input logic eo, input logic ee);
        logic [2:0] exp_alu_op;
        int n;
        exp_alu_op = (op == 3'b111) ? 3'b110 :
                     (op == 3'b000 || op == 3'b001 || op == 3'b010 || op == 3'b110) ? op : 3'b000;
        @(negedge clk);
        check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op; res_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = 16'h5A5A; req_b = 16'hA5A5; req_op = 3'b001;
        n = 0;
        while (!res_valid && n < 10) begin
            check({tag, " alu_op"}, 32'(alu_op), 32'(exp_alu_op));
            if (n == 0) begin
                check({tag, " alu_cin k0"}, 32'(alu_cin), 32'(op == 3'b110 || op == 3'b111));
                check({tag, " alu_a k0"}, 32'(alu_a), 32'(a[3:0]));
            end
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, 4);
        for (int s = 0; s < stall; s++) begin
            check({tag, " stall valid"}, 32'(res_valid), 32'd1);
            check({tag, " stall data"}, 32'(res_data), 32'(ed));
            check({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check({tag, " alu_op done"}, 32'(alu_op), 32'd0);
        check({tag, " data"}, 32'(res_data), 32'(ed));
        check({tag, " cout"}, 32'(res_cout), 32'(ec));
        check({tag, " ovf"}, 32'(res_ovf), 32'(eo));
        check({tag, " err"}, 32'(res_err), 32'(ee));
        check({tag, " req_ready done"}, 32'(req_ready), 32'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, " consumed"}, 32'(res_valid), 32'd0);
        check({tag, " req_ready after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; res_ready = 1'b0;
        #1;
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst res_data", 32'(res_data), 32'd0);
        check("rst alu_op", 32'(alu_op), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op("add_carry",  16'h00FF, 16'h0001, 3'b010, 0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_op("sub_neg",    16'h0000, 16'h0001, 3'b110, 0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 3'b010, 0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("slt_true",   16'h8000, 16'h0001, 3'b111, 0, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("slt_false",  16'h0001, 16'h8000, 3'b111, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap",   16'hFFFF, 16'h0001, 3'b010, 3, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("sub_pos",    16'h0005, 16'h0003, 3'b110, 0, 16'h0002, 1'b1, 1'b0, 1'b0);
        run_op("or",         16'h1200, 16'h0034, 3'b001, 0, 16'h1234, 1'b0, 1'b0, 1'b0);

        // Abort mid-RUN: two nibbles captured, third on the slice when rst hits
        @(negedge clk);
        req_valid = 1'b1; req_a = 16'h1234; req_b = 16'h1111; req_op = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("abort alu_a pre", 32'(alu_a), 32'h2);
        #2 rst = 1'b1;
        #1;
        check("abort alu_a async", 32'(alu_a), 32'd0);
        check("abort alu_op async", 32'(alu_op), 32'd0);
        check("abort req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        check("abort no result", seen, 0);

        run_op("and_after",  16'hF0F0, 16'hFF00, 3'b000, 0, 16'hF000, 1'b0, 1'b0, 1'b0);
        run_op("illegal",    16'hA5A5, 16'h5A5A, 3'b011, 0, 16'h0000, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
